// File: rtl/ff_piso_tx.sv
// Parallel-in serial-out transmitter with valid/last framing and an optional idle gap between frames.
// First bit appears 1 cycle after acceptance; din_ready only in IDLE, or on the last bit when GAP=0.
module ff_piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             D,
  output logic             D_valid,
  output logic             D_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_END  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gap_cnt;
  logic             w_last;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_IDX);
  assign din_ready = rst && ((r_state == ST_IDLE) || ((GAP == 0) && w_last));
  assign w_accept  = din_valid && din_ready;

  assign w_bit       = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    D           = 1'b0;
    D_valid     = 1'b0;
    D_last      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        D       = w_bit;
        D_valid = 1'b1;
        D_last  = w_last;
        busy    = 1'b1;
        // Back-to-back frames only possible without a gap: stay in SHIFT on a same-edge accept.
        if (w_last) begin
          if (w_accept)      w_state_nxt = ST_SHIFT;
          else if (GAP == 0) w_state_nxt = ST_IDLE;
          else               w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (r_gap_cnt == GAP_END) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else if (w_accept) begin
      r_shift <= din;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
      r_gap_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ff_piso_tx.sv
// Drives three ff_piso_tx variants (MSB/GAP1, LSB/GAP2, MSB/GAP0) from shared inputs and compares
// every output each cycle against a queue-of-expected-symbols model.
module tb_ff_piso_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic [2:0] rdy_o, d_o, dv_o, dl_o, bz_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, a circular buffer of pending output symbols {valid,last,d}.
  logic [2:0] mq [3][32];
  int         hd [3];
  int         nq [3];

  ff_piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(1)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_o[0]),
    .D(d_o[0]), .D_valid(dv_o[0]), .D_last(dl_o[0]), .busy(bz_o[0]));
  ff_piso_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_o[1]),
    .D(d_o[1]), .D_valid(dv_o[1]), .D_last(dl_o[1]), .busy(bz_o[1]));
  ff_piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_o[2]),
    .D(d_o[2]), .D_valid(dv_o[2]), .D_last(dl_o[2]), .busy(bz_o[2]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 0;
  endfunction

  function automatic int msb_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [2:0] f;
      logic       rdy;
      f   = (nq[i] > 0) ? mq[i][hd[i]] : 3'b000;
      rdy = rst && ((nq[i] == 0) || (gap_of(i) == 0 && nq[i] == 1));
      check($sformatf("D_valid[%0d]", i),   32'(dv_o[i]),  32'(f[2]));
      check($sformatf("D_last[%0d]", i),    32'(dl_o[i]),  32'(f[1]));
      check($sformatf("D[%0d]", i),         32'(d_o[i]),   32'(f[0]));
      check($sformatf("busy[%0d]", i),      32'(bz_o[i]),  32'(nq[i] > 0));
      check($sformatf("din_ready[%0d]", i), 32'(rdy_o[i]), 32'(rdy));
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        nq[i] = 0;
        hd[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic acc;
        int   idx;
        acc = din_valid && ((nq[i] == 0) || (gap_of(i) == 0 && nq[i] == 1));
        if (nq[i] > 0) begin
          hd[i] = (hd[i] + 1) % 32;
          nq[i]--;
        end
        if (acc) begin
          for (int b = 0; b < 4; b++) begin
            idx = (msb_of(i) != 0) ? 3 - b : b;
            mq[i][(hd[i] + nq[i]) % 32] = {1'b1, (b == 3), din[idx]};
            nq[i]++;
          end
          for (int g = 0; g < gap_of(i); g++) begin
            mq[i][(hd[i] + nq[i]) % 32] = 3'b000;
            nq[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) check_all();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    din       = 4'hF;
    din_valid = 1'b1;
    #1 rst = 1'b0;
    // Valid offered throughout reset must never be taken.
    idle_cycles(4);
    check("dv_in_reset", 32'(dv_o), 32'd0);
    #1;
    rst = 1'b1;
    din = 4'b1010;
    @(negedge clk); #1;
    din = 4'b0110;
    idle_cycles(12); #1;
    din_valid = 1'b0;
    idle_cycles(8); #1;

    // A held word changed while busy: only the value present at acceptance is sent.
    din       = 4'b0011;
    din_valid = 1'b1;
    @(negedge clk); #1;
    din = 4'b1111;
    idle_cycles(2); #1;
    din = 4'b0001;
    idle_cycles(8); #1;
    din_valid = 1'b0;
    idle_cycles(8); #1;

    // Asynchronous abort during bit 2 of a frame, then a clean frame afterwards.
    din       = 4'b1010;
    din_valid = 1'b1;
    @(negedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_dv", 32'(dv_o), 32'd0);
    check("async_busy", 32'(bz_o), 32'd0);
    check("async_d", 32'(d_o), 32'd0);
    check_all();
    idle_cycles(2); #1;
    rst       = 1'b1;
    din       = 4'b0101;
    din_valid = 1'b1;
    @(negedge clk); #1;
    din_valid = 1'b0;
    idle_cycles(10); #1;

    for (int c = 0; c < 600; c++) begin
      din       = 4'($urandom);
      din_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b0;
        #1 check_all();
        @(negedge clk); #1;
        rst = 1'b1;
      end
      @(negedge clk); #1;
    end
    din_valid = 1'b0;
    idle_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
